// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for each instruction and drives the datapath strobes decoded from the current
// state.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   op                   opcode from the instruction register (inst[31:26])
//   mem_ready            memory completes the current access this cycle
//   mem_req, mem_we      memory request / write qualifier
//   i_or_d               memory address source (0 PC, 1 ALUOut)
//   ir_wrt               instruction register load
//   pc_wrt, pc_wrt_cond  unconditional / zero-conditional PC write
//   pc_src               PC source (00 ALU, 01 ALUOut, 10 jump target)
//   reg_wrt, reg_dst     register-file write enable / destination (1 rd, 0 rt)
//   mem_reg              write-back source (1 MDR, 0 ALUOut)
//   alu_src_a, alu_src_b ALU operand selects
//   alu_op               ALU decoder control (00 add, 01 sub, 10 funct, 11 or)
//   instr_done           pulse in the final state of every instruction
//   illegal_op           pulse on an unknown opcode in DECODE
//   bus_err              pulse on a memory handshake timeout
//   halted               high while in HALT
//   state                current state encoding (debug)
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_wrt,
    output logic       pc_wrt,
    output logic       pc_wrt_cond,
    output logic [1:0] pc_src,
    output logic       reg_wrt,
    output logic       reg_dst,
    output logic       mem_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err,
    output logic       halted,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = 8;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_ORIEX  = 4'd10,
        S_ORIWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mem_wait;
    logic             timeout_hit;

    assign state = state_q;

    // States that hold a memory handshake open
    assign mem_wait    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // Ready in the same cycle as the limit takes priority over the error
    assign timeout_hit = mem_wait && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

    // State and timeout-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)        state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_MEMWR: begin
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ORIEX:  state_d = S_ORIWB;
            S_ORIWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        // Count only while staying in a wait state; any entry, ready or exit clears it
        if (mem_wait && !mem_ready && (state_d == state_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Output decode from the current state
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        i_or_d      = 1'b0;
        ir_wrt      = 1'b0;
        pc_wrt      = 1'b0;
        pc_wrt_cond = 1'b0;
        pc_src      = 2'b00;
        reg_wrt     = 1'b0;
        reg_dst     = 1'b0;
        mem_reg     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        bus_err     = timeout_hit;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_wrt    = mem_ready;
                pc_wrt    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_BEQ, OP_ORI, OP_J: ;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_wrt    = 1'b1;
                mem_reg    = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_wrt    = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_op      = 2'b01;
                pc_wrt_cond = 1'b1;
                pc_src      = 2'b01;
                instr_done  = 1'b1;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_ORIWB: begin
                reg_wrt    = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_wrt     = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks state plus every strobe per cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, i_or_d, ir_wrt, pc_wrt, pc_wrt_cond;
    logic [1:0] pc_src;
    logic       reg_wrt, reg_dst, mem_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       instr_done, illegal_op, bus_err, halted;
    logic [3:0] state;
    logic [19:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_wrt(ir_wrt),
        .pc_wrt(pc_wrt), .pc_wrt_cond(pc_wrt_cond), .pc_src(pc_src),
        .reg_wrt(reg_wrt), .reg_dst(reg_dst), .mem_reg(mem_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .illegal_op(illegal_op), .bus_err(bus_err),
        .halted(halted), .state(state)
    );

    // Field order: req we iord irw pcw pcwc pcsrc regw dst memreg srca srcb aluop done ill berr halt
    assign ctl = {mem_req, mem_we, i_or_d, ir_wrt, pc_wrt, pc_wrt_cond, pc_src,
                  reg_wrt, reg_dst, mem_reg, alu_src_a, alu_src_b, alu_op,
                  instr_done, illegal_op, bus_err, halted};

    localparam logic [19:0] C_ZERO      = 20'b0;
    localparam logic [19:0] C_FETCH_RDY = 20'b1_0_0_1_1_0_00_0_0_0_0_01_00_0_0_0_0;
    localparam logic [19:0] C_FETCH_WT  = 20'b1_0_0_0_0_0_00_0_0_0_0_01_00_0_0_0_0;
    localparam logic [19:0] C_FETCH_ERR = 20'b1_0_0_0_0_0_00_0_0_0_0_01_00_0_0_1_0;
    localparam logic [19:0] C_DECODE    = 20'b0_0_0_0_0_0_00_0_0_0_0_11_00_0_0_0_0;
    localparam logic [19:0] C_DEC_ILL   = 20'b0_0_0_0_0_0_00_0_0_0_0_11_00_1_1_0_0;
    localparam logic [19:0] C_MEMADR    = 20'b0_0_0_0_0_0_00_0_0_0_1_10_00_0_0_0_0;
    localparam logic [19:0] C_MEMRD     = 20'b1_0_1_0_0_0_00_0_0_0_0_00_00_0_0_0_0;
    localparam logic [19:0] C_MEMWB     = 20'b0_0_0_0_0_0_00_1_0_1_0_00_00_1_0_0_0;
    localparam logic [19:0] C_MEMWR_WT  = 20'b1_1_1_0_0_0_00_0_0_0_0_00_00_0_0_0_0;
    localparam logic [19:0] C_MEMWR_RDY = 20'b1_1_1_0_0_0_00_0_0_0_0_00_00_1_0_0_0;
    localparam logic [19:0] C_EXEC      = 20'b0_0_0_0_0_0_00_0_0_0_1_00_10_0_0_0_0;
    localparam logic [19:0] C_RWB       = 20'b0_0_0_0_0_0_00_1_1_0_0_00_00_1_0_0_0;
    localparam logic [19:0] C_BRANCH    = 20'b0_0_0_0_0_1_01_0_0_0_1_00_01_1_0_0_0;
    localparam logic [19:0] C_ORIEX     = 20'b0_0_0_0_0_0_00_0_0_0_1_10_11_0_0_0_0;
    localparam logic [19:0] C_ORIWB     = 20'b0_0_0_0_0_0_00_1_0_0_0_00_00_1_0_0_0;
    localparam logic [19:0] C_JUMP      = 20'b0_0_0_0_1_0_10_0_0_0_0_00_00_1_0_0_0;
    localparam logic [19:0] C_HALT      = 20'b0_0_0_0_0_0_00_0_0_0_0_00_00_0_0_0_1;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (state !== 4'd0 || ctl !== C_ZERO) begin
            n_fail++; $display("FAIL rst_hold state=%0d ctl=%b exp 0 %b", state, ctl, C_ZERO);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd0 || ctl !== C_ZERO) begin
            n_fail++; $display("FAIL idle state=%0d ctl=%b exp 0 %b", state, ctl, C_ZERO);
        end
        tick();
        mem_ready = 1'b1; op = 6'b000000;
        #1;
        n_tests++;
        if (state !== 4'd1 || ctl !== C_FETCH_RDY) begin
            n_fail++; $display("FAIL rst_fetch state=%0d ctl=%b exp 1 %b", state, ctl, C_FETCH_RDY);
        end
        tick(); tick();
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd7 || ctl !== C_EXEC) begin
            n_fail++; $display("FAIL rst_exec state=%0d ctl=%b exp 7 %b", state, ctl, C_EXEC);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd0 || ctl !== C_ZERO) begin
            n_fail++; $display("FAIL rst_async state=%0d ctl=%b exp 0 %b", state, ctl, C_ZERO);
        end
        tick();
        n_tests++;
        if (state !== 4'd0 || ctl !== C_ZERO) begin
            n_fail++; $display("FAIL rst_no_wb state=%0d ctl=%b exp 0 %b", state, ctl, C_ZERO);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL rst_release state=%0d exp 1", state);
        end
    endtask

    task automatic test_lw();
        int done_cnt;
        logic [3:0]  exp_s [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        logic [19:0] exp_c [5] = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB};
        done_cnt = 0;
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1;
            #1;
            n_tests++;
            if (state !== exp_s[i] || ctl !== exp_c[i]) begin
                n_fail++; $display("FAIL lw_c%0d state=%0d ctl=%b exp %0d %b", i + 1, state, ctl, exp_s[i], exp_c[i]);
            end
            if (instr_done) done_cnt++;
            tick();
        end
        n_tests++;
        if (done_cnt != 1 || state !== 4'd1) begin
            n_fail++; $display("FAIL lw_done done=%0d state=%0d exp 1 1", done_cnt, state);
        end
    endtask

    task automatic test_sw();
        int reqwe_cnt;
        reqwe_cnt = 0;
        op = 6'b101011;
        mem_ready = 1'b1;
        tick(); tick();
        n_tests++;
        if (state !== 4'd3 || ctl !== C_MEMADR) begin
            n_fail++; $display("FAIL sw_memadr state=%0d ctl=%b exp 3 %b", state, ctl, C_MEMADR);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            n_tests++;
            if (state !== 4'd6 || ctl !== ((i == 3) ? C_MEMWR_RDY : C_MEMWR_WT)) begin
                n_fail++; $display("FAIL sw_memwr_c%0d state=%0d ctl=%b exp 6 %b", i, state, ctl,
                                   (i == 3) ? C_MEMWR_RDY : C_MEMWR_WT);
            end
            if (mem_req && mem_we) reqwe_cnt++;
            tick();
        end
        n_tests++;
        if (reqwe_cnt != 4 || state !== 4'd1) begin
            n_fail++; $display("FAIL sw_hold reqwe=%0d state=%0d exp 4 1", reqwe_cnt, state);
        end
    endtask

    task automatic test_beq_j();
        logic [3:0]  exp_s [6] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd12};
        logic [19:0] exp_c [6] = '{C_FETCH_RDY, C_DECODE, C_BRANCH, C_FETCH_RDY, C_DECODE, C_JUMP};
        for (int i = 0; i < 6; i++) begin
            op = (i < 3) ? 6'b000100 : 6'b000010;
            mem_ready = 1'b1;
            #1;
            n_tests++;
            if (state !== exp_s[i] || ctl !== exp_c[i]) begin
                n_fail++; $display("FAIL beq_j_c%0d state=%0d ctl=%b exp %0d %b", i, state, ctl, exp_s[i], exp_c[i]);
            end
            tick();
        end
    endtask

    task automatic test_r_ori();
        logic [3:0]  exp_s [8] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1, 4'd2, 4'd10, 4'd11};
        logic [19:0] exp_c [8] = '{C_FETCH_RDY, C_DECODE, C_EXEC, C_RWB,
                                   C_FETCH_RDY, C_DECODE, C_ORIEX, C_ORIWB};
        for (int i = 0; i < 8; i++) begin
            op = (i < 4) ? 6'b000000 : 6'b001101;
            mem_ready = 1'b1;
            #1;
            n_tests++;
            if (state !== exp_s[i] || ctl !== exp_c[i]) begin
                n_fail++; $display("FAIL r_ori_c%0d state=%0d ctl=%b exp %0d %b", i, state, ctl, exp_s[i], exp_c[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        op = 6'b111111;
        mem_ready = 1'b1;
        tick();
        n_tests++;
        if (state !== 4'd2 || ctl !== C_DEC_ILL) begin
            n_fail++; $display("FAIL illegal_decode state=%0d ctl=%b exp 2 %b", state, ctl, C_DEC_ILL);
        end
        tick();
        n_tests++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL illegal_return state=%0d exp 1", state);
        end
    endtask

    task automatic test_timeout();
        // Ready arriving on the 16th wait cycle beats the error
        op = 6'b000010;
        for (int i = 1; i <= 16; i++) begin
            mem_ready = (i == 16);
            #1;
            n_tests++;
            if (state !== 4'd1 || ctl !== ((i == 16) ? C_FETCH_RDY : C_FETCH_WT)) begin
                n_fail++; $display("FAIL to_late_rdy_c%0d state=%0d ctl=%b", i, state, ctl);
            end
            tick();
        end
        n_tests++;
        if (state !== 4'd2) begin
            n_fail++; $display("FAIL to_late_rdy_decode state=%0d exp 2", state);
        end
        tick(); tick();
        // No ready at all: error on the 16th FETCH cycle
        for (int i = 1; i <= 16; i++) begin
            mem_ready = 1'b0;
            #1;
            n_tests++;
            if (state !== 4'd1 || ctl !== ((i == 16) ? C_FETCH_ERR : C_FETCH_WT)) begin
                n_fail++; $display("FAIL to_err_c%0d state=%0d ctl=%b", i, state, ctl);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            #1;
            n_tests++;
            if (state !== 4'd13 || ctl !== C_HALT) begin
                n_fail++; $display("FAIL halt_c%0d state=%0d ctl=%b exp 13 %b", i, state, ctl, C_HALT);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd0 || ctl !== C_ZERO) begin
            n_fail++; $display("FAIL halt_rst state=%0d ctl=%b exp 0 %b", state, ctl, C_ZERO);
        end
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL halt_exit state=%0d exp 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq_j();
        test_r_ori();
        test_illegal();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
